// File: rtl/step_pulse_generator.sv
// Step/direction pulse generator for a stepper motor driver, with trapezoidal
// acceleration ramp and an Avalon-MM register interface.
// Ports:
//   csi_MCLK_clk, rsi_MRST_reset  - clock, async active-high reset
//   avs_ctrl_*                    - Avalon-MM slave, 8 word registers, read latency 1
//   step_out                      - step pulse, high for PULSE_WIDTH clocks per step
//   dir_out                       - direction, latched at move start
//   busy                          - move in progress
//   irq                           - level interrupt, done & irq_en
module step_pulse_generator #(
  parameter int unsigned PULSE_WIDTH = 4
) (
  input  logic        csi_MCLK_clk,
  input  logic        rsi_MRST_reset,
  input  logic [2:0]  avs_ctrl_address,
  input  logic        avs_ctrl_write,
  input  logic [31:0] avs_ctrl_writedata,
  input  logic [3:0]  avs_ctrl_byteenable,
  input  logic        avs_ctrl_read,
  output logic [31:0] avs_ctrl_readdata,
  output logic        avs_ctrl_waitrequest,
  output logic        step_out,
  output logic        dir_out,
  output logic        busy,
  output logic        irq
);

  localparam int unsigned DW = 32;
  localparam logic [DW-1:0] PW      = DW'(PULSE_WIDTH);
  localparam logic [DW-1:0] EFF_MIN = DW'(2 * PULSE_WIDTH);

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_STEPS  = 3'd1;
  localparam logic [2:0] A_START  = 3'd2;
  localparam logic [2:0] A_MIN    = 3'd3;
  localparam logic [2:0] A_ACCEL  = 3'd4;
  localparam logic [2:0] A_STATUS = 3'd5;
  localparam logic [2:0] A_POS    = 3'd6;
  localparam logic [2:0] A_REM    = 3'd7;

  typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2} state_t;

  state_t state, state_d;

  logic [DW-1:0] steps, start_period, min_period, accel;
  logic [DW-1:0] position, remaining, cur_period, start_snap, ramp;
  logic [DW-1:0] cnt, cnt_d, low_len;
  logic          dir_reg, irq_en, done, aborted, start_req, stop_req;
  logic          take_start, issue, finish, abort;
  logic          done_n, aborted_n, irq_en_n;
  logic [DW-1:0] rem_dec, inc, dec, cur_n, ramp_n, eff, low_len_n;
  logic [DW:0]   sum;
  logic [DW-1:0] rd_mux;
  logic          wr_ctrl, wr_status;

  assign avs_ctrl_waitrequest = 1'b0;
  assign wr_ctrl   = avs_ctrl_write && (avs_ctrl_address == A_CTRL);
  assign wr_status = avs_ctrl_write && (avs_ctrl_address == A_STATUS);

  // Byte-lane merge of write data into an existing register value.
  function automatic logic [DW-1:0] merge_be(input logic [DW-1:0] cur,
                                             input logic [DW-1:0] wd,
                                             input logic [3:0]    be);
    logic [DW-1:0] r;
    r = cur;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    end
    return r;
  endfunction

  // State register.
  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) state <= IDLE;
    else                state <= state_d;
  end

  // Next state. A start parks in LOW with cnt=0 so the first rising edge
  // follows one cycle later, giving dir_out a cycle of setup.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    take_start = 1'b0;
    issue      = 1'b0;
    finish     = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (start_req) begin
          state_d    = LOW;
          cnt_d      = '0;
          take_start = 1'b1;
        end
      end
      HIGH: begin
        if (cnt == '0) begin
          if (stop_req) begin
            state_d = IDLE;
            finish  = 1'b1;
            abort   = 1'b1;
          end else begin
            state_d = LOW;
            cnt_d   = low_len - DW'(1);
          end
        end else begin
          cnt_d = cnt - DW'(1);
        end
      end
      LOW: begin
        if (stop_req) begin
          state_d = IDLE;
          finish  = 1'b1;
          abort   = 1'b1;
        end else if (cnt == '0) begin
          if (remaining == '0) begin
            state_d = IDLE;
            finish  = 1'b1;
          end else begin
            state_d = HIGH;
            issue   = 1'b1;
            cnt_d   = PW - DW'(1);
          end
        end else begin
          cnt_d = cnt - DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ramp step applied at each rising edge; both directions saturate.
  always_comb begin
    rem_dec = remaining - DW'(1);
    sum     = {1'b0, cur_period} + {1'b0, accel};
    inc     = (sum > {1'b0, start_snap}) ? start_snap : sum[DW-1:0];
    if ((accel > cur_period) || ((cur_period - accel) < min_period)) dec = min_period;
    else                                                             dec = cur_period - accel;
    cur_n  = cur_period;
    ramp_n = ramp;
    if (rem_dec <= ramp) begin
      cur_n  = inc;
      ramp_n = (ramp == '0) ? '0 : ramp - DW'(1);
    end else if (cur_period > min_period) begin
      cur_n  = dec;
      ramp_n = ramp + DW'(1);
    end
    eff       = (cur_n > EFF_MIN) ? cur_n : EFF_MIN;
    low_len_n = eff - PW;
  end

  // Status flag updates; completion wins over a same-cycle clear.
  always_comb begin
    done_n    = done;
    aborted_n = aborted;
    irq_en_n  = irq_en;
    if (wr_ctrl) irq_en_n = avs_ctrl_writedata[3];
    if (wr_status && avs_ctrl_writedata[1]) begin
      done_n    = 1'b0;
      aborted_n = 1'b0;
    end
    if (take_start) done_n    = 1'b0;
    if (finish)     done_n    = 1'b1;
    if (abort)      aborted_n = 1'b1;
  end

  // Read data mux.
  always_comb begin
    rd_mux = '0;
    case (avs_ctrl_address)
      A_CTRL:   rd_mux = {28'b0, irq_en, dir_reg, 2'b0};
      A_STEPS:  rd_mux = steps;
      A_START:  rd_mux = start_period;
      A_MIN:    rd_mux = min_period;
      A_ACCEL:  rd_mux = accel;
      A_STATUS: rd_mux = {29'b0, aborted, done, busy};
      A_POS:    rd_mux = position;
      A_REM:    rd_mux = remaining;
      default:  rd_mux = '0;
    endcase
  end

  // Registers, datapath and registered outputs.
  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      step_out          <= 1'b0;
      busy              <= 1'b0;
      irq               <= 1'b0;
      dir_out           <= 1'b0;
      done              <= 1'b0;
      aborted           <= 1'b0;
      dir_reg           <= 1'b0;
      irq_en            <= 1'b0;
      start_req         <= 1'b0;
      stop_req          <= 1'b0;
      steps             <= '0;
      start_period      <= '0;
      min_period        <= '0;
      accel             <= '0;
      position          <= '0;
      remaining         <= '0;
      cur_period        <= '0;
      start_snap        <= '0;
      ramp              <= '0;
      cnt               <= '0;
      low_len           <= '0;
      avs_ctrl_readdata <= '0;
    end else begin
      step_out  <= (state_d == HIGH);
      busy      <= (state_d != IDLE);
      cnt       <= cnt_d;
      done      <= done_n;
      aborted   <= aborted_n;
      irq_en    <= irq_en_n;
      irq       <= done_n & irq_en_n;
      // Start together with stop is treated as stop only.
      start_req <= wr_ctrl & avs_ctrl_writedata[0] & ~avs_ctrl_writedata[1];
      // Stop is held until the FSM acts on it; in IDLE it is simply dropped.
      stop_req  <= (wr_ctrl & avs_ctrl_writedata[1]) | (stop_req & (state != IDLE) & ~abort);

      if (wr_ctrl) dir_reg <= avs_ctrl_writedata[2];
      if (avs_ctrl_write) begin
        case (avs_ctrl_address)
          A_STEPS: steps        <= merge_be(steps, avs_ctrl_writedata, avs_ctrl_byteenable);
          A_START: start_period <= merge_be(start_period, avs_ctrl_writedata, avs_ctrl_byteenable);
          A_MIN:   min_period   <= merge_be(min_period, avs_ctrl_writedata, avs_ctrl_byteenable);
          A_ACCEL: accel        <= merge_be(accel, avs_ctrl_writedata, avs_ctrl_byteenable);
          default: ;
        endcase
      end

      if (take_start) begin
        remaining  <= steps;
        cur_period <= start_period;
        start_snap <= start_period;
        dir_out    <= dir_reg;
        ramp       <= '0;
      end else if (issue) begin
        remaining  <= rem_dec;
        cur_period <= cur_n;
        ramp       <= ramp_n;
        low_len    <= low_len_n;
      end

      if (issue) begin
        position <= dir_out ? position + DW'(1) : position - DW'(1);
      end else if (avs_ctrl_write && (avs_ctrl_address == A_POS) && (state == IDLE)) begin
        position <= merge_be(position, avs_ctrl_writedata, avs_ctrl_byteenable);
      end

      if (avs_ctrl_read) avs_ctrl_readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_step_pulse_generator.sv
// Testbench for step_pulse_generator: directed moves, with expected register
// reads and step pulses queued by the stimulus and checked by monitors.
module tb_step_pulse_generator;

  localparam logic [2:0] A_CTRL = 3'd0, A_STEPS = 3'd1, A_START = 3'd2, A_MIN = 3'd3;
  localparam logic [2:0] A_ACCEL = 3'd4, A_STATUS = 3'd5, A_POS = 3'd6, A_REM = 3'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        read;
  logic [31:0] readdata;
  logic        waitrequest;
  logic        step_out, dir_out, busy, irq;

  typedef struct { int rise; int width; } pulse_t;
  pulse_t      pq[$];
  logic [31:0] rq[$];
  string       rn[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  step_pulse_generator #(.PULSE_WIDTH(4)) dut (
    .csi_MCLK_clk         (clk),
    .rsi_MRST_reset       (rst),
    .avs_ctrl_address     (address),
    .avs_ctrl_write       (write),
    .avs_ctrl_writedata   (writedata),
    .avs_ctrl_byteenable  (byteenable),
    .avs_ctrl_read        (read),
    .avs_ctrl_readdata    (readdata),
    .avs_ctrl_waitrequest (waitrequest),
    .step_out             (step_out),
    .dir_out              (dir_out),
    .busy                 (busy),
    .irq                  (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic read_monitor();
    logic        seen;
    logic [31:0] e;
    string       n;
    forever begin
      @(posedge clk);
      seen = read;
      @(negedge clk);
      if (seen) begin
        if (rq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_read: readdata 0x%08h with no expectation", readdata);
        end else begin
          e = rq.pop_front();
          n = rn.pop_front();
          check(n, readdata, e);
        end
      end
    end
  endtask

  task automatic pulse_monitor();
    logic   prev = 1'b0;
    bit     have = 1'b0;
    int     rise_t = 0;
    pulse_t cur;
    forever begin
      @(negedge clk);
      if (step_out === 1'b1 && prev == 1'b0) begin
        if (pq.size() == 0) begin
          checks++;
          errors++;
          have = 1'b0;
          $display("FAIL unexpected_pulse: step_out rose at cycle %0d, none expected", cyc);
        end else begin
          cur    = pq.pop_front();
          have   = 1'b1;
          rise_t = cyc;
          check("pulse_rise_cycle", 32'(cyc), 32'(cur.rise));
        end
      end else if (step_out == 1'b0 && prev == 1'b1 && have) begin
        if (cur.width != 0) check("pulse_width", 32'(cyc - rise_t), 32'(cur.width));
        have = 1'b0;
      end
      prev = step_out;
    end
  endtask

  task automatic push_pulse(input int rise, input int width);
    pulse_t p;
    p.rise  = rise;
    p.width = width;
    pq.push_back(p);
  endtask

  // Returns at the negedge following the write edge, t = that edge's cycle.
  task automatic wr_be(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be, output int t);
    @(negedge clk);
    address    = a;
    writedata  = d;
    byteenable = be;
    write      = 1'b1;
    @(negedge clk);
    write = 1'b0;
    t     = cyc;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    int t;
    wr_be(a, d, 4'hF, t);
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
    @(negedge clk);
    address = a;
    read    = 1'b1;
    rq.push_back(exp);
    rn.push_back(name);
    @(negedge clk);
    read = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_idle(output int t);
    int  n;
    bit  got;
    n   = 0;
    got = 1'b0;
    t   = -1;
    while (!got && n < 3000) begin
      @(negedge clk);
      n++;
      if (!busy) begin
        got = 1'b1;
        t   = cyc;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy still high after %0d cycles", n);
    end
  endtask

  initial begin
    int t, td;
    rst = 1'b1; address = '0; write = 1'b0; writedata = '0; byteenable = '0; read = 1'b0;
    fork
      read_monitor();
      pulse_monitor();
    join_none
    repeat (3) @(negedge clk);
    check("rst_step_out", {31'b0, step_out}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    check("rst_dir_out", {31'b0, dir_out}, 32'd0);
    check("rst_readdata", readdata, 32'd0);
    check("waitrequest", {31'b0, waitrequest}, 32'd0);
    rst = 1'b0;
    rd(A_STATUS, 32'd0, "rst_status");
    rd(A_POS, 32'd0, "rst_position");
    rd(A_STEPS, 32'd0, "rst_steps");
    rd(A_CTRL, 32'd0, "rst_ctrl");

    // Byte-lane writes
    wr(A_STEPS, 32'hFFFF_FFFF);
    wr_be(A_STEPS, 32'h1234_5678, 4'b0101, t);
    rd(A_STEPS, 32'hFF34_FF78, "byteenable_steps");

    // Constant-speed move, forward
    wr(A_STEPS, 32'd3); wr(A_START, 32'd20); wr(A_MIN, 32'd20); wr(A_ACCEL, 32'd0);
    wr_be(A_CTRL, 32'h5, 4'hF, t);
    push_pulse(t + 2, 4); push_pulse(t + 22, 4); push_pulse(t + 42, 4);
    check("a_busy_at_start", {31'b0, busy}, 32'd0);
    @(negedge clk);
    check("a_busy_t1", {31'b0, busy}, 32'd1);
    check("a_dir_out", {31'b0, dir_out}, 32'd1);
    wait_idle(td);
    check("a_done_cycle", 32'(td), 32'(t + 62));
    check("a_irq_disabled", {31'b0, irq}, 32'd0);
    rd(A_POS, 32'd3, "a_position");
    rd(A_STATUS, 32'h2, "a_status");
    rd(A_REM, 32'd0, "a_remaining");

    // Ramped move, reverse: intervals 80,60,60,80,100 then a final 100
    wr(A_POS, 32'd0);
    wr(A_STEPS, 32'd6); wr(A_START, 32'd100); wr(A_MIN, 32'd60); wr(A_ACCEL, 32'd20);
    wr_be(A_CTRL, 32'h1, 4'hF, t);
    push_pulse(t + 2, 4);   push_pulse(t + 82, 4);  push_pulse(t + 142, 4);
    push_pulse(t + 202, 4); push_pulse(t + 282, 4); push_pulse(t + 382, 4);
    @(negedge clk);
    check("b_busy_t1", {31'b0, busy}, 32'd1);
    check("b_dir_out", {31'b0, dir_out}, 32'd0);
    wait_idle(td);
    check("b_done_cycle", 32'(td), 32'(t + 482));
    rd(A_POS, 32'hFFFF_FFFA, "b_position");
    rd(A_STATUS, 32'h2, "b_status");
    rd(A_REM, 32'd0, "b_remaining");
    rd(A_CTRL, 32'h0, "b_ctrl");

    // Zero-step move with interrupt enabled
    wr(A_STATUS, 32'h2);
    rd(A_STATUS, 32'h0, "c_status_cleared");
    wr(A_STEPS, 32'd0);
    wr_be(A_CTRL, 32'h9, 4'hF, t);
    @(negedge clk);
    check("c_busy_t1", {31'b0, busy}, 32'd1);
    check("c_irq_t1", {31'b0, irq}, 32'd0);
    @(negedge clk);
    check("c_busy_t2", {31'b0, busy}, 32'd0);
    check("c_irq_t2", {31'b0, irq}, 32'd1);
    rd(A_STATUS, 32'h2, "c_status_done");
    rd(A_CTRL, 32'h8, "c_ctrl");
    wr(A_STATUS, 32'h2);
    check("c_irq_cleared", {31'b0, irq}, 32'd0);
    rd(A_STATUS, 32'h0, "c_status_after_clear");

    // Stop during third pulse; POSITION write while busy is ignored
    wr(A_POS, 32'd0);
    wr(A_STEPS, 32'd10); wr(A_START, 32'd50); wr(A_MIN, 32'd50); wr(A_ACCEL, 32'd0);
    wr_be(A_CTRL, 32'h5, 4'hF, t);
    push_pulse(t + 2, 4); push_pulse(t + 52, 4); push_pulse(t + 102, 4);
    wait_cyc(t + 10);
    wr(A_POS, 32'd100);
    wait_cyc(t + 102);
    check("d_step_high", {31'b0, step_out}, 32'd1);
    wr(A_CTRL, 32'h6);
    wait_idle(td);
    check("d_stop_cycle", 32'(td), 32'(t + 106));
    check("d_dir_out", {31'b0, dir_out}, 32'd1);
    rd(A_STATUS, 32'h6, "d_status");
    rd(A_REM, 32'd7, "d_remaining");
    rd(A_POS, 32'd3, "d_position");

    // Period below 2*PULSE_WIDTH, start while busy ignored
    wr(A_STATUS, 32'h2);
    wr(A_STEPS, 32'd3); wr(A_START, 32'd3); wr(A_MIN, 32'd3);
    wr(A_POS, 32'd0);
    wr_be(A_CTRL, 32'h5, 4'hF, t);
    push_pulse(t + 2, 4); push_pulse(t + 10, 4); push_pulse(t + 18, 4);
    wait_cyc(t + 4);
    wr(A_CTRL, 32'h5);
    wait_idle(td);
    check("e_done_cycle", 32'(td), 32'(t + 26));
    rd(A_POS, 32'd3, "e_position");
    rd(A_STATUS, 32'h2, "e_status");

    // Asynchronous reset during HIGH
    wr(A_STEPS, 32'd5); wr(A_START, 32'd20); wr(A_MIN, 32'd20);
    wr_be(A_CTRL, 32'h5, 4'hF, t);
    push_pulse(t + 2, 0);
    wait_cyc(t + 2);
    check("f_step_high", {31'b0, step_out}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("f_async_step_out", {31'b0, step_out}, 32'd0);
    check("f_async_busy", {31'b0, busy}, 32'd0);
    check("f_async_dir_out", {31'b0, dir_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rd(A_POS, 32'd0, "f_position");
    rd(A_STEPS, 32'd0, "f_steps");
    rd(A_REM, 32'd0, "f_remaining");
    rd(A_STATUS, 32'd0, "f_status");

    repeat (5) @(negedge clk);
    check("pulses_outstanding", 32'(pq.size()), 32'd0);
    check("reads_outstanding", 32'(rq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/step_pulse_generator.md
STEP_PULSE_GENERATOR -- requirements
Module: step_pulse_generator

Interface
REQ-001 The block SHALL have one parameter: PULSE_WIDTH, default 4, the step_out high time in clocks (≥1).
REQ-002 The block SHALL have one clock, csi_MCLK_clk, and the reset rsi_MRST_reset, which is asynchronous and active-high.
REQ-003 The block SHALL have these ports:
- csi_MCLK_clk, input, 1 bit: system clock.
- rsi_MRST_reset, input, 1 bit: asynchronous active-high reset.
- avs_ctrl_address, input, 3 bits: word address.
- avs_ctrl_write, input, 1 bit: write strobe.
- avs_ctrl_writedata, input, 32 bits: write data.
- avs_ctrl_byteenable, input, 4 bits: byte lanes for registers 1-4 and 6.
- avs_ctrl_read, input, 1 bit: read strobe.
- avs_ctrl_readdata, output, 32 bits: registered read data.
- avs_ctrl_waitrequest, output, 1 bit: constant 0.
- step_out, output, 1 bit: step pulse to the motor driver's step input.
- dir_out, output, 1 bit: direction to the driver's forward_back input.
- busy, output, 1 bit: a move is in progress.
- irq, output, 1 bit: done interrupt (level).

Function
REQ-004 The register map SHALL be:
- 0 CTRL: W bit0 start (self-clearing), bit1 stop (self-clearing), bit2 dir, bit3 irq_en; R {28'b0, irq_en, dir, 2'b0}.
- 1 STEPS: R/W.
- 2 START_PERIOD: R/W.
- 3 MIN_PERIOD: R/W.
- 4 ACCEL: R/W.
- 5 STATUS: R {29'b0, aborted, done, busy}; writing 1 to bit1 clears both done and aborted.
- 6 POSITION: R/W, signed.
- 7 REMAINING: read-only.
REQ-005 Reads SHALL update avs_ctrl_readdata on the clock edge where avs_ctrl_read=1 (read latency 1); readdata holds otherwise.
REQ-006 The FSM SHALL have states IDLE, HIGH and LOW; busy=1 in every state except IDLE.
REQ-007 Start from IDLE, written at edge T, SHALL:
- snapshot STEPS into remaining, START_PERIOD into cur_period, and dir into dir_out;
- clear ramp and done;
- assert busy at T+1;
- give the first step_out rising edge at T+2, so dir_out has one cycle of setup.
REQ-008 Start while busy SHALL be ignored; a write with start=1 and stop=1 together SHALL act as stop only.
REQ-009 Effective period SHALL be max(cur_period, 2*PULSE_WIDTH) clocks between successive step_out rising edges; step_out SHALL be high for exactly PULSE_WIDTH clocks (HIGH), then low for the rest of the period (LOW).
REQ-010 At each step_out rising edge:
- remaining SHALL decrement by 1;
- POSITION SHALL change by +1 if dir_out=1, or -1 if dir_out=0, wrapping modulo 2^32.
REQ-011 At each rising edge, after the decrement, the period for the next step SHALL be set as follows:
- if remaining ≤ ramp (decel): cur_period=min(cur_period+ACCEL, START_PERIOD snapshot) and ramp=max(ramp-1,0);
- else if cur_period > MIN_PERIOD (accel): cur_period=max(cur_period-ACCEL, MIN_PERIOD) and ramp+=1;
- otherwise cur_period SHALL be unchanged.
REQ-012 MIN_PERIOD and ACCEL SHALL be read live; writes to them while busy take effect from the next rising edge. STEPS, START_PERIOD and dir SHALL be used only at start.
REQ-013 Period arithmetic SHALL be 32-bit unsigned; subtraction SHALL saturate at MIN_PERIOD, and addition SHALL saturate at the START_PERIOD snapshot (no wrap).
REQ-014 When remaining reaches 0, the FSM SHALL return to IDLE at the end of LOW, with done=1 and busy=0 on the same edge.
REQ-015 Start with STEPS=0 SHALL produce no pulse; busy SHALL be high for exactly one cycle (T+1), with done=1 at T+2.
REQ-016 Stop while busy:
- in HIGH, the current pulse SHALL complete its full PULSE_WIDTH, then the FSM goes to IDLE;
- in LOW, the FSM SHALL go to IDLE on the next edge;
- in both cases done=1 and aborted=1; REMAINING SHALL hold the unissued count.
REQ-017 Writes to POSITION while busy SHALL be ignored.
REQ-018 irq SHALL equal done & irq_en.
REQ-019 dir_out SHALL change only on a start edge.

Reset
REQ-020 Reset SHALL force:
- FSM to IDLE;
- step_out, busy, irq, done, aborted, dir_out, irq_en to 0;
- POSITION, REMAINING, ramp, readdata to 0;
- STEPS, START_PERIOD, MIN_PERIOD, ACCEL to 0.
REQ-021 Reset asserted mid-move SHALL drop step_out to 0 immediately (asynchronously), truncating any pulse.

Verification
REQ-022 STEPS=3, START=MIN=20, ACCEL=0, dir=1, start at T: rising edges at T+2, T+22, T+42, each pulse 4 clocks high; done at T+62; POSITION=3.
REQ-023 STEPS=6, START=100, MIN=60, ACCEL=20, dir=0: intervals 80, 60, 60, 80, 100; POSITION=-6; ramp=0 at done.
REQ-024 STEPS=0, start: no step_out; busy high one cycle; done=1; irq=1 when irq_en=1; writing STATUS=0x2 clears done and irq.
REQ-025 STEPS=10, START=MIN=50; stop written during the third pulse's HIGH: pulse stays 4 clocks; then IDLE, aborted=1, REMAINING=7, POSITION=3.
REQ-026 START=3, PULSE_WIDTH=4: rising-edge interval is 8. Start while busy: ignored. Reset asserted in HIGH: step_out=0 with no clock edge.
